// File: rtl/pc_redirect_pkg.sv
// Shared constants, next-PC select encoding and BTB index helper for the
// fetch-side PC redirect unit.
package pc_redirect_pkg;

    localparam int XLEN  = 32;
    localparam int IDX_W = 3;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_HOLD,
        NPC_PRED,
        NPC_FALL,
        NPC_TGT
    } npc_sel_e;

    // Word-aligned PCs, so the index skips the two byte-offset bits.
    function automatic logic [IDX_W-1:0] btb_index(input logic [XLEN-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter used for the branch and mispredict statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         INC,
    output logic [W-1:0] COUNT
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Sticks at all-ones so long runs never wrap back to a misleading small value.
    always_comb begin
        count_d = count_q;
        if (INC && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register, next-PC selection, pipeline flush strobes and the
// ID-to-EX branch record that feeds the dynamic branch predictor.
module pc_redirect_unit #(
    parameter int              XLEN         = pc_redirect_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IDX_W        = pc_redirect_pkg::IDX_W,
    parameter int              CNT_W        = pc_redirect_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             ID_BRANCH,
    input  logic [XLEN-1:0]  ID_PC,
    input  logic [XLEN-1:0]  ID_TARGET,
    input  logic             TAKE_BRANCH,
    input  logic             FLUSH,
    input  logic             EARLY_PREDICTION,
    output logic [XLEN-1:0]  PC,
    output logic [IDX_W-1:0] BTB_ID_IDX,
    output logic [IDX_W-1:0] BTB_ALU_IDX,
    output logic             EX_BRANCH_VALID,
    output logic             FLUSH_IF_ID,
    output logic             FLUSH_ID_EX,
    output logic [CNT_W-1:0] BRANCH_COUNT,
    output logic [CNT_W-1:0] MISPREDICT_COUNT
);

    import pc_redirect_pkg::*;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             exValid_q, exValid_d;
    logic [IDX_W-1:0] exIdx_q, exIdx_d;
    logic [XLEN-1:0]  exFall_q, exFall_d;
    logic [XLEN-1:0]  exTarget_q, exTarget_d;

    logic     mis;
    logic     pred;
    npc_sel_e npcSel;

    // A FLUSH with no tracked branch in EX is stale and must not redirect.
    assign mis  = FLUSH & exValid_q;
    assign pred = ID_BRANCH & TAKE_BRANCH & ~STALL & ~mis;

    always_comb begin
        npcSel = NPC_SEQ;
        if (mis) begin
            npcSel = EARLY_PREDICTION ? NPC_FALL : NPC_TGT;
        end else if (pred) begin
            npcSel = NPC_PRED;
        end else if (STALL) begin
            npcSel = NPC_HOLD;
        end
    end

    always_comb begin
        pc_d = pc_q + XLEN'(4);
        case (npcSel)
            NPC_HOLD: pc_d = pc_q;
            NPC_PRED: pc_d = ID_TARGET;
            NPC_FALL: pc_d = exFall_q;
            NPC_TGT:  pc_d = exTarget_q;
            default:  pc_d = pc_q + XLEN'(4);
        endcase
    end

    // Recovery kills the ID branch so it never reaches EX, even under stall.
    always_comb begin
        exValid_d  = exValid_q;
        exIdx_d    = exIdx_q;
        exFall_d   = exFall_q;
        exTarget_d = exTarget_q;
        if (mis) begin
            exValid_d = 1'b0;
        end else if (!STALL) begin
            exValid_d  = ID_BRANCH;
            exIdx_d    = btb_index(ID_PC);
            exFall_d   = ID_PC + XLEN'(4);
            exTarget_d = ID_TARGET;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q       <= RESET_VECTOR;
            exValid_q  <= 1'b0;
            exIdx_q    <= '0;
            exFall_q   <= '0;
            exTarget_q <= '0;
        end else begin
            pc_q       <= pc_d;
            exValid_q  <= exValid_d;
            exIdx_q    <= exIdx_d;
            exFall_q   <= exFall_d;
            exTarget_q <= exTarget_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (exValid_q & (~STALL | mis)),
        .COUNT (BRANCH_COUNT)
    );

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (mis),
        .COUNT (MISPREDICT_COUNT)
    );

    assign PC              = pc_q;
    assign BTB_ID_IDX      = btb_index(ID_PC);
    assign BTB_ALU_IDX     = exIdx_q;
    assign EX_BRANCH_VALID = exValid_q;
    assign FLUSH_IF_ID     = RESET & (mis | pred);
    assign FLUSH_ID_EX     = RESET & mis;

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-side companion to the dynamic branch predictor. It owns the fetch PC register, feeds the predictor its ID-stage and ALU-stage BTB indices, and records every in-flight branch from ID into EX. It consumes the predictor's TAKE_BRANCH, FLUSH and EARLY_PREDICTION outputs, selects the next PC, and raises the IF/ID and ID/EX flush strobes. It also keeps saturating branch and mispredict counters for performance monitoring.

## Interface
- XLEN, 32, address width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- IDX_W, 3, BTB index width (predictor has 2^IDX_W entries)
- CNT_W, 16, width of the statistics counters
- CLK  in  1  single clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- STALL  in  1  global pipeline stall; freezes PC and the EX branch record
- ID_BRANCH  in  1  instruction in ID is a conditional branch
- ID_PC  in  XLEN  PC of the instruction in ID
- ID_TARGET  in  XLEN  ID_PC + b_imm, from the ID-stage adder
- TAKE_BRANCH  in  1  predictor: predict taken for the ID branch
- FLUSH  in  1  predictor: EX branch was mispredicted
- EARLY_PREDICTION  in  1  predictor: 1 = recover to fall-through, 0 = recover to target
- PC  out  XLEN  current fetch address (registered)
- BTB_ID_IDX  out  IDX_W  ID_PC[IDX_W+1:2], drives the predictor ID_PC input
- BTB_ALU_IDX  out  IDX_W  index of the branch in EX, drives the predictor ALU_PC input
- EX_BRANCH_VALID  out  1  EX holds a tracked branch, drives the predictor ALU_STAGE_BRANCH input
- FLUSH_IF_ID  out  1  squash the IF/ID register this cycle
- FLUSH_ID_EX  out  1  squash the ID/EX register this cycle
- BRANCH_COUNT  out  CNT_W  branches resolved since reset
- MISPREDICT_COUNT  out  CNT_W  mispredictions since reset

## Operation
- EX record registers:
  - ex_valid
  - ex_idx (ID_PC[IDX_W+1:2])
  - ex_fall (ID_PC+4, modulo 2^XLEN)
  - ex_target
- BTB_ALU_IDX equals ex_idx. EX_BRANCH_VALID equals ex_valid.
- mis = FLUSH & ex_valid. FLUSH with ex_valid=0 is ignored: no redirect, no count.
- pred = ID_BRANCH & TAKE_BRANCH & !STALL & !mis.
- Next-PC priority, highest first:
  - mis: EARLY_PREDICTION ? ex_fall : ex_target. This overrides STALL.
  - pred: ID_TARGET.
  - STALL: hold PC.
  - otherwise: PC+4.
- Combinational flush strobes:
  - FLUSH_IF_ID = mis | pred.
  - FLUSH_ID_EX = mis.
- EX record update:
  - mis: ex_valid <= 0, overriding STALL. The branch in ID is squashed and never enters EX.
  - else if !STALL: ex_valid <= ID_BRANCH, and the address fields load from ID.
  - else: hold all fields.
- Counters saturate at all-ones and never wrap.
  - BRANCH_COUNT += 1 when ex_valid & (!STALL | mis).
  - MISPREDICT_COUNT += 1 when mis.
- Reset (RESET=0, asynchronous):
  - PC = RESET_VECTOR, ex_valid = 0, ex_idx/ex_fall/ex_target = 0, both counters = 0.
  - FLUSH_IF_ID and FLUSH_ID_EX are forced to 0 while reset is asserted.
  - Reset asserted mid-redirect discards the pending redirect. Fetch restarts at RESET_VECTOR on the first edge after release.

## Timing
- PC changes only on the CLK rising edge. A redirect decided in cycle N appears on PC in cycle N+1.
- Flush strobes are valid in the same cycle as the decision and are sampled by the pipeline registers at that cycle's edge.
- Predicted-taken penalty: 1 bubble. Misprediction penalty: 2 bubbles.
- Simultaneous mis and pred: mis wins. FLUSH_IF_ID=1, FLUSH_ID_EX=1, PC <= recovery address, and ID_TARGET is ignored.
- TAKE_BRANCH under STALL is not acted on. It is re-evaluated each cycle until STALL drops, so the redirect happens exactly once.
- Back-to-back branches in ID and EX are each tracked independently. BTB_ID_IDX is combinational from ID_PC. BTB_ALU_IDX is registered.

## Structure
- Shared package pc_redirect_pkg:
  - XLEN, IDX_W, CNT_W.
  - Next-PC select enum: NPC_SEQ, NPC_HOLD, NPC_PRED, NPC_FALL, NPC_TGT.
  - Function for the BTB index slice.
- One sub-module, sat_counter: parameter W, ports CLK, RESET, INC, COUNT. Instantiate twice.
- The next-PC mux, flush logic and EX record live in the top module.

## Test plan
- Reset with RESET_VECTOR=32'h100, release, no branches, 3 cycles → PC = 0x100, 0x104, 0x108, 0x10C; both flushes 0; counters 0.
- ID_BRANCH=1, ID_PC=0x200, ID_TARGET=0x240, TAKE_BRANCH=1 → FLUSH_IF_ID=1 that cycle; next PC=0x240; next cycle EX_BRANCH_VALID=1, BTB_ALU_IDX=0.
- From the previous state, FLUSH=1 with EARLY_PREDICTION=1 → FLUSH_IF_ID=FLUSH_ID_EX=1; next PC=0x204; MISPREDICT_COUNT=1, BRANCH_COUNT=1.
- Same-cycle FLUSH=1 with EARLY_PREDICTION=0 (ex_target=0x300) and a new TAKE_BRANCH in ID (ID_TARGET=0x500) → PC=0x300; ex_valid=0 next cycle.
- STALL=1 held 2 cycles with TAKE_BRANCH=1 → PC held and FLUSH_IF_ID=0 during the stall; after STALL drops, FLUSH_IF_ID=1 for exactly one cycle and PC=ID_TARGET.
- Drive 0xFFFF+3 mispredicts with CNT_W=16 → MISPREDICT_COUNT saturates at 0xFFFF. Assert RESET mid-stall → PC=RESET_VECTOR immediately (asynchronous) and counters=0.
